// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serializes one 16-bit {rw, addr[6:0], data[7:0]} frame per
// accepted request, MSB first, with setup, hold and inter-frame gap of CLK_DIV cycles each.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       copi,
  output logic       cs_n
);
  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam int unsigned SW = 15;

  // The peripheral's two-flop synchronizers need at least two cycles per sclk level.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [3:0]    bit_cnt, bit_cnt_next;
  logic [SW-1:0] shreg, shreg_next;
  logic          copi_next, sclk_next, cs_n_next, busy_next, done_next;
  logic          half_end;

  assign half_end  = (cnt == CNT_MAX);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= {CW{1'b0}};
      bit_cnt <= 4'd0;
      shreg   <= {SW{1'b0}};
      copi    <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      copi    <= copi_next;
      sclk    <= sclk_next;
      cs_n    <= cs_n_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  // Bit 15 goes straight to copi at acceptance; shreg holds the remaining 15 bits.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    copi_next    = copi;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next   = LOW;
          cnt_next     = {CW{1'b0}};
          bit_cnt_next = 4'd15;
          shreg_next   = {req_addr, req_data};
          copi_next    = req_write;
        end
      end
      LOW: begin
        cnt_next = half_end ? {CW{1'b0}} : cnt + CW'(1);
        if (half_end) state_next = HIGH;
      end
      HIGH: begin
        cnt_next = half_end ? {CW{1'b0}} : cnt + CW'(1);
        if (half_end) begin
          if (bit_cnt == 4'd0) begin
            state_next = HOLD;
          end else begin
            state_next   = LOW;
            bit_cnt_next = bit_cnt - 4'd1;
            shreg_next   = {shreg[SW-2:0], 1'b0};
            copi_next    = shreg[SW-1];
          end
        end
      end
      HOLD: begin
        cnt_next = half_end ? {CW{1'b0}} : cnt + CW'(1);
        if (half_end) begin
          state_next = GAP;
          copi_next  = 1'b0;
        end
      end
      GAP: begin
        cnt_next = half_end ? {CW{1'b0}} : cnt + CW'(1);
        if (half_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    sclk_next = (state_next == HIGH);
    cs_n_next = !(state_next inside {LOW, HIGH, HOLD});
    busy_next = (state_next != IDLE);
    done_next = (state == HOLD) && (state_next == GAP);
  end
endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: lane 0 runs CLK_DIV=4, lane 1 runs CLK_DIV=2.
module tb_spi_controller;
  localparam int H0 = 4;
  localparam int H1 = 2;

  typedef struct {
    logic [15:0] frame;
    int          acc;
  } exp_t;

  logic       clk;
  logic [1:0] rst;
  logic [1:0] req_valid, req_write;
  logic [6:0] req_addr [2];
  logic [7:0] req_data [2];
  logic [1:0] req_ready, busy, done, sclk, copi, cs_n;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [2][$];

  bit   [1:0]  in_frame = 2'b00;
  bit   [1:0]  wait_rdy = 2'b00;
  int          fall_s [2];
  int          first_rise [2];
  int          nrise [2];
  int          rdy_due [2];
  logic [15:0] shift [2];
  logic [1:0]  p_cs_n = 2'b11;
  logic [1:0]  p_sclk = 2'b00;
  logic [1:0]  p_copi = 2'b00;
  logic [7:0]  regs [2][128];

  spi_controller #(.CLK_DIV(H0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
    .busy(busy[0]), .done(done[0]), .sclk(sclk[0]), .copi(copi[0]), .cs_n(cs_n[0])
  );

  spi_controller #(.CLK_DIV(H1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
    .busy(busy[1]), .done(done[1]), .sclk(sclk[1]), .copi(copi[1]), .cs_n(cs_n[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d @cyc %0d: got 0x%0h, expected 0x%0h", name, g, cyc, act, exp);
    end
  endtask

  // Monitor: decodes frames off the pins, pops the scoreboard and checks timing against acceptance.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      automatic int   h       = (g == 0) ? H0 : H1;
      automatic logic cs_rise = in_frame[g] && cs_n[g] && !p_cs_n[g];
      automatic exp_t e;
      if (rst[g]) begin
        in_frame[g] = 1'b0;
        wait_rdy[g] = 1'b0;
      end else begin
        chk("copi_moved_while_sclk_high", g, 32'(sclk[g] && (copi[g] != p_copi[g])), 0);
        chk("sclk_moved_while_cs_high", g, 32'(cs_n[g] && p_cs_n[g] && (sclk[g] != p_sclk[g])), 0);
        chk("done_only_at_cs_rise", g, 32'(done[g]), 32'(cs_rise));
        if (p_cs_n[g] && !cs_n[g]) begin
          in_frame[g]   = 1'b1;
          fall_s[g]     = cyc;
          first_rise[g] = -1;
          nrise[g]      = 0;
          shift[g]      = 16'h0000;
          chk("busy_at_frame_start", g, 32'(busy[g]), 1);
        end
        if (in_frame[g] && sclk[g] && !p_sclk[g]) begin
          shift[g] = {shift[g][14:0], copi[g]};
          if (nrise[g] == 0) first_rise[g] = cyc;
          nrise[g]++;
        end
        if (cs_rise) begin
          in_frame[g] = 1'b0;
          if (nrise[g] == 16 && shift[g][15]) regs[g][shift[g][14:8]] = shift[g][7:0];
          if (exp_q[g].size() == 0) begin
            chk("unexpected_frame", g, 32'(shift[g]), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[g].pop_front();
            chk("frame_bits", g, 32'(shift[g]), 32'(e.frame));
            chk("sclk_rise_count", g, nrise[g], 16);
            chk("cs_fall_cycle", g, fall_s[g], e.acc);
            chk("first_sclk_rise_cycle", g, first_rise[g], e.acc + h);
            chk("cs_rise_cycle", g, cyc, e.acc + 33 * h);
            rdy_due[g]  = e.acc + 34 * h;
            wait_rdy[g] = 1'b1;
          end
        end
        if (wait_rdy[g]) begin
          if (cyc == rdy_due[g] - 1) begin
            chk("ready_low_in_gap", g, 32'(req_ready[g]), 0);
            chk("busy_high_in_gap", g, 32'(busy[g]), 1);
          end else if (cyc == rdy_due[g]) begin
            chk("ready_after_gap", g, 32'(req_ready[g]), 1);
            chk("busy_after_gap", g, 32'(busy[g]), 0);
            wait_rdy[g] = 1'b0;
          end
        end
      end
      p_cs_n[g] = cs_n[g];
      p_sclk[g] = sclk[g];
      p_copi[g] = copi[g];
    end
  end

  task automatic wait_ready(input int g);
    for (int i = 0; i < 400 && !req_ready[g]; i++) begin
      @(posedge clk);
      #1;
    end
    chk("ready_wait_timeout", g, 32'(req_ready[g]), 1);
  endtask

  task automatic send(input int g, input logic w, input logic [6:0] a, input logic [7:0] d,
                      input bit expect_frame, output int acc);
    wait_ready(g);
    req_write[g] = w;
    req_addr[g]  = a;
    req_data[g]  = d;
    req_valid[g] = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    if (expect_frame) exp_q[g].push_back('{frame: {w, a, d}, acc: acc});
    req_valid[g] = 1'b0;
  endtask

  initial begin
    int a1, a2, acc;
    rst       = 2'b11;
    req_valid = 2'b00;
    req_write = 2'b00;
    for (int g = 0; g < 2; g++) begin
      req_addr[g] = 7'h00;
      req_data[g] = 8'h00;
      for (int r = 0; r < 128; r++) regs[g][r] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reset_cs_n", g, 32'(cs_n[g]), 1);
      chk("reset_sclk", g, 32'(sclk[g]), 0);
      chk("reset_copi", g, 32'(copi[g]), 0);
      chk("reset_busy", g, 32'(busy[g]), 0);
      chk("reset_done", g, 32'(done[g]), 0);
      chk("reset_req_ready", g, 32'(req_ready[g]), 1);
    end
    rst = 2'b00;
    @(posedge clk);
    #1;

    // Single write: reg 0x04 <= 0x80, frame 0x8480.
    send(0, 1'b1, 7'h04, 8'h80, 1'b1, acc);

    // Held req_valid, inputs changed the cycle after each acceptance.
    wait_ready(0);
    req_write[0] = 1'b1;
    req_addr[0]  = 7'h00;
    req_data[0]  = 8'hA5;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    a1 = cyc;
    exp_q[0].push_back('{frame: 16'h80A5, acc: a1});
    @(posedge clk);
    #1;
    req_addr[0] = 7'h04;
    req_data[0] = 8'h80;
    a2 = a1 + 34 * H0 + 1;
    exp_q[0].push_back('{frame: 16'h8480, acc: a2});
    repeat (a2 - cyc) @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req_write[0] = 1'b0;
    req_addr[0]  = 7'h11;
    req_data[0]  = 8'h22;
    req_valid[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    req_write[0] = 1'b1;
    req_addr[0]  = 7'h33;
    req_data[0]  = 8'h5A;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;

    // Reset during bit 7's HIGH phase of frame 0x88BC (bit 7 = 1).
    send(0, 1'b1, 7'h08, 8'hBC, 1'b0, acc);
    repeat (acc + 17 * H0 + 1 - cyc) @(posedge clk);
    #1;
    chk("pre_reset_sclk_high", 0, 32'(sclk[0]), 1);
    chk("pre_reset_copi_bit7", 0, 32'(copi[0]), 1);
    rst[0] = 1'b1;
    #1;
    chk("midframe_reset_cs_n", 0, 32'(cs_n[0]), 1);
    chk("midframe_reset_sclk", 0, 32'(sclk[0]), 0);
    chk("midframe_reset_copi", 0, 32'(copi[0]), 0);
    chk("midframe_reset_busy", 0, 32'(busy[0]), 0);
    chk("midframe_reset_ready", 0, 32'(req_ready[0]), 1);
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    send(0, 1'b1, 7'h04, 8'h80, 1'b1, acc);

    // CLK_DIV=2, read-flagged frame 0x7FFF.
    send(1, 1'b0, 7'h7F, 8'hFF, 1'b1, acc);

    for (int i = 0; i < 2000 && (exp_q[0].size() != 0 || exp_q[1].size() != 0 || wait_rdy != 2'b00); i++)
      @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("frames_outstanding", 0, exp_q[0].size(), 0);
    chk("frames_outstanding", 1, exp_q[1].size(), 0);
    chk("reg_00", 0, 32'(regs[0][0]), 32'h A5);
    chk("reg_04", 0, 32'(regs[0][4]), 32'h80);
    chk("reg_08_after_abort", 0, 32'(regs[0][8]), 32'h00);
    chk("reg_33_busy_pulse", 0, 32'(regs[0][51]), 32'h00);
    chk("reg_7f_write0_ignored", 1, 32'(regs[1][127]), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
